// File: rtl/clutter_recur_filter.sv
// First-order recursive clutter-map update y = k*x + (1-k)*yprev, with a frame-synchronous
// coefficient latch and first-frame init FSM. Optional detection flag: define CLUT_RECUR_DET_EN.
module clutter_recur_filter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned COEF_FRAC = 10,
  parameter int unsigned IDX_W     = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              frame_start,
  input  logic              init_req,
  input  logic [COEF_W-1:0] coeff_k,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_yprev,
  input  logic [DATA_W-1:0] det_offset,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_y,
  output logic              out_sof,
  output logic [IDX_W-1:0]  out_idx,
  output logic              det_flag,
  output logic              coeff_err
);

  localparam int unsigned KW  = COEF_FRAC + 1;
  localparam int unsigned PW  = DATA_W + COEF_FRAC + 1;
  localparam int unsigned SW  = PW + 1;
  localparam int unsigned DW1 = DATA_W + 1;

  localparam logic [KW-1:0]     ONE_K  = {1'b1, {COEF_FRAC{1'b0}}};
  localparam logic [COEF_W-1:0] ONE_C  = COEF_W'(ONE_K);
  localparam logic [SW-1:0]     HALF_S = SW'(1) << (COEF_FRAC - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [KW-1:0] k_r;
  logic          sof_pend;

  logic          accept_c;
  logic          init_mode_c;
  logic          sof_c;
  logic          det_c;
  logic [KW-1:0] k_clamp_c;
  logic [KW-1:0] k_eff_c;

  // Pipeline stage registers
  logic              s1_vld, s1_init, s1_sof, s1_det;
  logic [DATA_W-1:0] s1_x, s1_yp;
  logic [KW-1:0]     s1_k;
  logic              s2_vld, s2_init, s2_sof, s2_det;
  logic [DATA_W-1:0] s2_x;
  logic [PW-1:0]     s2_p0, s2_p1;
  logic              s3_vld, s3_init, s3_sof, s3_det;
  logic [DATA_W-1:0] s3_x;
  logic [SW-1:0]     s3_s;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: transitions happen only on frame_start
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      case (state_q)
        ST_IDLE: state_d = ST_INIT;
        ST_INIT: state_d = init_req ? ST_INIT : ST_RUN;
        ST_RUN:  state_d = init_req ? ST_INIT : ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Sample qualification uses the post-transition state so a frame_start sample sees its new frame
  always_comb begin
    accept_c    = in_vld && (state_d != ST_IDLE);
    init_mode_c = (state_d == ST_INIT);
    sof_c       = frame_start | sof_pend;
    k_clamp_c   = (coeff_k > ONE_C) ? ONE_K : KW'(coeff_k);
    k_eff_c     = frame_start ? k_clamp_c : k_r;
  end

`ifdef CLUT_RECUR_DET_EN
  logic [DW1-1:0] det_thr_c;
  assign det_thr_c = DW1'(in_yprev) + DW1'(det_offset);
  assign det_c     = (DW1'(in_x) > det_thr_c);
`else
  logic det_offset_unused;
  assign det_offset_unused = ^det_offset;
  assign det_c             = 1'b0;
`endif

  // Frame-level control: coefficient latch, error flag, pending SOF tag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      k_r       <= '0;
      coeff_err <= 1'b0;
      sof_pend  <= 1'b0;
    end else begin
      if (frame_start) begin
        k_r       <= k_clamp_c;
        coeff_err <= (coeff_k > ONE_C);
      end
      if (accept_c) begin
        sof_pend <= 1'b0;
      end else if (frame_start) begin
        sof_pend <= 1'b1;
      end
    end
  end

  // S1..S3: capture, multiply, sum with round-half-up
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      s1_vld  <= 1'b0;
      s1_init <= 1'b0;
      s1_sof  <= 1'b0;
      s1_det  <= 1'b0;
      s1_x    <= '0;
      s1_yp   <= '0;
      s1_k    <= '0;
      s2_vld  <= 1'b0;
      s2_init <= 1'b0;
      s2_sof  <= 1'b0;
      s2_det  <= 1'b0;
      s2_x    <= '0;
      s2_p0   <= '0;
      s2_p1   <= '0;
      s3_vld  <= 1'b0;
      s3_init <= 1'b0;
      s3_sof  <= 1'b0;
      s3_det  <= 1'b0;
      s3_x    <= '0;
      s3_s    <= '0;
    end else begin
      s1_vld  <= accept_c;
      s1_init <= init_mode_c;
      s1_sof  <= sof_c;
      s1_det  <= det_c;
      s1_x    <= in_x;
      s1_yp   <= in_yprev;
      s1_k    <= k_eff_c;

      s2_vld  <= s1_vld;
      s2_init <= s1_init;
      s2_sof  <= s1_sof;
      s2_det  <= s1_det;
      s2_x    <= s1_x;
      s2_p0   <= PW'(s1_x) * PW'(s1_k);
      s2_p1   <= PW'(s1_yp) * PW'(ONE_K - s1_k);

      s3_vld  <= s2_vld;
      s3_init <= s2_init;
      s3_sof  <= s2_sof;
      s3_det  <= s2_det;
      s3_x    <= s2_x;
      s3_s    <= SW'(s2_p0) + SW'(s2_p1) + HALF_S;
    end
  end

  // S4: output register; data and index hold through bubbles, tags are qualified by valid
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      out_vld  <= 1'b0;
      out_y    <= '0;
      out_sof  <= 1'b0;
      out_idx  <= '0;
      det_flag <= 1'b0;
    end else begin
      out_vld  <= s3_vld;
      out_sof  <= s3_vld & s3_sof;
      det_flag <= s3_vld & s3_det & ~s3_init;
      if (s3_vld) begin
        out_y   <= s3_init ? s3_x : DATA_W'(s3_s >> COEF_FRAC);
        out_idx <= s3_sof ? '0 : out_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clutter_recur_filter.sv
// Directed bench for clutter_recur_filter; det_flag expectations follow CLUT_RECUR_DET_EN.
module tb_clutter_recur_filter;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        init_req = 1'b0;
  logic [15:0] coeff_k = 16'd0;
  logic        in_vld = 1'b0;
  logic [15:0] in_x = 16'd0;
  logic [15:0] in_yprev = 16'd0;
  logic [15:0] det_offset = 16'd100;
  logic        out_vld;
  logic [15:0] out_y;
  logic        out_sof;
  logic [15:0] out_idx;
  logic        det_flag;
  logic        coeff_err;

  int vectors = 0;
  int miscompares = 0;

  clutter_recur_filter dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .frame_start(frame_start),
    .init_req   (init_req),
    .coeff_k    (coeff_k),
    .in_vld     (in_vld),
    .in_x       (in_x),
    .in_yprev   (in_yprev),
    .det_offset (det_offset),
    .out_vld    (out_vld),
    .out_y      (out_y),
    .out_sof    (out_sof),
    .out_idx    (out_idx),
    .det_flag   (det_flag),
    .coeff_err  (coeff_err)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic det_exp(input logic d);
`ifdef CLUT_RECUR_DET_EN
    return d;
`else
    return 1'b0 & d;
`endif
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] ey, input logic esof,
                         input logic [15:0] eidx, input logic edet);
    chk({tag, ".vld"}, 32'(out_vld), 32'd1);
    chk({tag, ".y"}, 32'(out_y), 32'(ey));
    chk({tag, ".sof"}, 32'(out_sof), 32'(esof));
    chk({tag, ".idx"}, 32'(out_idx), 32'(eidx));
    chk({tag, ".det"}, 32'(det_flag), 32'(det_exp(edet)));
  endtask

  task automatic new_frame(input logic [15:0] k, input logic init);
    frame_start = 1'b1;
    coeff_k     = k;
    init_req    = init;
    tick();
    frame_start = 1'b0;
    init_req    = 1'b0;
  endtask

  // One isolated sample: checks out_vld is low one cycle early, then the result at latency 4
  task automatic single(input string tag, input logic [15:0] x, input logic [15:0] yp,
                        input logic [15:0] ey, input logic esof, input logic [15:0] eidx,
                        input logic edet);
    in_vld = 1'b1; in_x = x; in_yprev = yp;
    tick();
    in_vld = 1'b0;
    tick();
    tick();
    chk({tag, ".early"}, 32'(out_vld), 32'd0);
    tick();
    chk_out(tag, ey, esof, eidx, edet);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst.vld", 32'(out_vld), 32'd0);
    chk("rst.y", 32'(out_y), 32'd0);
    chk("rst.sof", 32'(out_sof), 32'd0);
    chk("rst.idx", 32'(out_idx), 32'd0);
    chk("rst.det", 32'(det_flag), 32'd0);
    chk("rst.cerr", 32'(coeff_err), 32'd0);
    sys_rst = 1'b0;

    // IDLE ignores samples
    in_vld = 1'b1; in_x = 16'd11; in_yprev = 16'd22;
    for (int i = 0; i < 5; i++) tick();
    in_vld = 1'b0;
    chk("idle.vld", 32'(out_vld), 32'd0);

    // First frame after reset is an init frame: y = x
    new_frame(16'd256, 1'b0);
    single("init", 16'd1234, 16'd7, 16'd1234, 1'b1, 16'd0, 1'b0);

    // Over-range coefficient clamps to 1.0 and raises coeff_err
    new_frame(16'd2000, 1'b0);
    chk("clamp.cerr", 32'(coeff_err), 32'd1);
    single("clamp", 16'd55, 16'd900, 16'd55, 1'b1, 16'd0, 1'b0);

    // Basic recursion, k = 0.25
    new_frame(16'd256, 1'b0);
    chk("basic.cerr", 32'(coeff_err), 32'd0);
    single("basic", 16'd1000, 16'd200, 16'd400, 1'b1, 16'd0, 1'b1);

    // Rounding, k = 0.5
    new_frame(16'd512, 1'b0);
    single("rnd0", 16'd3, 16'd0, 16'd2, 1'b1, 16'd0, 1'b0);
    single("rnd1", 16'd1, 16'd0, 16'd1, 1'b0, 16'd1, 1'b0);

    // Full-rate streaming at the top of range, k = 300/1024
    new_frame(16'd300, 1'b0);
    for (int t = 0; t < 11; t++) begin
      in_vld = (t < 8); in_x = 16'hFFFF; in_yprev = 16'hFFFF;
      tick();
      if (t >= 3) chk_out($sformatf("stream%0d", t - 3), 16'hFFFF, (t == 3), 16'(t - 3), 1'b0);
    end
    in_vld = 1'b0;
    tick();
    chk("stream.end", 32'(out_vld), 32'd0);

    // Frame edge: coefficient change coincides with a sample
    new_frame(16'd256, 1'b0);
    in_vld = 1'b1; in_x = 16'd1000; in_yprev = 16'd200;
    tick();
    frame_start = 1'b1; coeff_k = 16'd768;
    tick();
    frame_start = 1'b0; in_vld = 1'b0;
    tick();
    tick();
    chk_out("edge.a", 16'd400, 1'b1, 16'd0, 1'b1);
    tick();
    chk_out("edge.b", 16'd800, 1'b1, 16'd0, 1'b1);

    // Detection threshold boundary, offset 100
    new_frame(16'd256, 1'b0);
    in_vld = 1'b1; in_x = 16'd500; in_yprev = 16'd399;
    tick();
    in_yprev = 16'd400;
    tick();
    in_vld = 1'b0;
    tick();
    tick();
    chk_out("det.a", 16'd424, 1'b1, 16'd0, 1'b1);
    tick();
    chk_out("det.b", 16'd425, 1'b0, 16'd1, 1'b0);

    // Reset with three samples in flight
    in_vld = 1'b1; in_x = 16'd500; in_yprev = 16'd100;
    tick();
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("mrst%0d.vld", i), 32'(out_vld), 32'd0);
      chk($sformatf("mrst%0d.y", i), 32'(out_y), 32'd0);
      chk($sformatf("mrst%0d.idx", i), 32'(out_idx), 32'd0);
      chk($sformatf("mrst%0d.det", i), 32'(det_flag), 32'd0);
      tick();
    end
    in_vld = 1'b0;
    chk("mrst.cerr", 32'(coeff_err), 32'd0);

    // Restart: first frame is again an init frame
    new_frame(16'd256, 1'b0);
    single("reinit", 16'd77, 16'd5, 16'd77, 1'b1, 16'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
